// File: rtl/bp_pkg.sv
// Shared types and tree pseudo-LRU helpers for the bp_cache_nway store.
// Tree bits use heap order: node 0 is the root, children of n are 2n+1 and 2n+2.
// A node bit of 0 points the victim into the left (lower-way) subtree.
// Helpers are sized for up to 8 ways (7 tree bits, 3 levels); callers pass
// the number of levels actually in use.
package bp_pkg;

    typedef enum logic [0:0] {
        BP_IDLE  = 1'b0,
        BP_FLUSH = 1'b1
    } bp_state_t;

    localparam int PLRU_MAX_LVLS = 3;

    // Follow the node bits from the root down to a leaf; the path is the victim way.
    function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int levels);
        logic [2:0] node;
        logic [2:0] way;
        node = '0;
        way  = '0;
        for (int l = 0; l < PLRU_MAX_LVLS; l++) begin
            if (l < levels) begin
                way  = {way[1:0], bits[node]};
                node = (node << 1) + 3'd1 + {2'b00, bits[node]};
            end
        end
        return way;
    endfunction

    // Walk the accessed way's path and make every node on it point the other way.
    function automatic logic [6:0] plru_touch(input logic [6:0] bits, input logic [2:0] way,
                                              input int levels);
        logic [6:0] res;
        logic [2:0] node;
        logic [2:0] path;
        logic       dir;
        res  = bits;
        node = '0;
        path = way << (PLRU_MAX_LVLS - levels);
        for (int l = 0; l < PLRU_MAX_LVLS; l++) begin
            if (l < levels) begin
                dir       = path[2];
                path      = path << 1;
                res[node] = ~dir;
                node      = (node << 1) + 3'd1 + {2'b00, dir};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_cache_nway_plru.sv
// Combinational tree pseudo-LRU for one set: victim selection and the
// updated tree after an access. Victim depends only on the current bits,
// so a caller may feed the victim back into the access way.
module bp_plru_tree
    import bp_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         bits,
    input  logic [$clog2(WAYS)-1:0] way,
    input  logic                    valid,
    output logic [WAYS-2:0]         bits_next,
    output logic [$clog2(WAYS)-1:0] victim
);

    localparam int WW = $clog2(WAYS);

    logic [6:0] bits_wide;
    logic [2:0] way_wide;
    logic [6:0] touched_wide;
    logic [2:0] victim_wide;
    logic       unused_wide;

    // Widen the tree bits and way to the helper width.
    always_comb begin
        bits_wide           = '0;
        bits_wide[WAYS-2:0] = bits;
        way_wide            = '0;
        way_wide[WW-1:0]    = way;
    end

    assign victim_wide  = plru_victim(bits_wide, WW);
    assign touched_wide = plru_touch(bits_wide, way_wide, WW);
    assign unused_wide  = ^{touched_wide, victim_wide};

    assign victim    = victim_wide[WW-1:0];
    assign bits_next = valid ? touched_wide[WAYS-2:0] : bits;

endmodule

// File: rtl/bp_cache_nway.sv
// N-way set-associative branch-prediction store: two combinational read
// ports, one synchronous write port, tree PLRU replacement with
// invalid-way-first allocation, and a one-set-per-cycle flush engine.
// Optional macro BP_CACHE_FWD_EN: a write forwards its payload to a read
// port addressing the same tag/index in the same cycle.
//
// state    | meaning
// BP_IDLE  | normal operation, reads/writes/PLRU updates active
// BP_FLUSH | walking sets 0..SETS-1 clearing valid and PLRU bits; busy=1
module bp_cache_nway
    import bp_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int LINES  = 128,
    parameter int WAYS   = 4,
    parameter int OFFSET = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] ra0,
    output logic [DWIDTH-1:0] dout0,
    output logic              hit0,
    input  logic [AWIDTH-1:0] ra1,
    output logic [DWIDTH-1:0] dout1,
    output logic              hit1,
    input  logic [AWIDTH-1:0] wa,
    input  logic [DWIDTH-1:0] din,
    input  logic              we,
    input  logic              flush,
    output logic              busy
);

    localparam int SETS = LINES / WAYS;
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = AWIDTH - OFFSET - IDX;
    localparam int WW   = $clog2(WAYS);

    logic [TAGW-1:0]   tag_mem   [WAYS][SETS];
    logic [DWIDTH-1:0] data_mem  [WAYS][SETS];
    logic [WAYS-1:0]   valid_mem [SETS];
    logic [WAYS-2:0]   plru_mem  [SETS];

    bp_state_t         state, state_next;
    logic [IDX-1:0]    cnt;

    logic [AWIDTH-1:0] ra        [2];
    logic [IDX-1:0]    rset      [2];
    logic [TAGW-1:0]   rtag      [2];
    logic [WW-1:0]     rway      [2];
    logic [DWIDTH-1:0] rdata     [2];
    logic [1:0]        rhit;
    logic [WAYS-2:0]   rplru_next[2];
    logic [WW-1:0]     rvictim_unused [2];
    logic              upd0, upd1;

    logic [IDX-1:0]    wset;
    logic [TAGW-1:0]   wtag;
    logic              whit;
    logic [WW-1:0]     wway_hit;
    logic              any_inv;
    logic [WW-1:0]     first_inv;
    logic [WW-1:0]     wvictim;
    logic [WW-1:0]     wway;
    logic [WAYS-2:0]   wplru_next;
    logic              we_eff;

    function automatic logic [IDX-1:0] idx_of(input logic [AWIDTH-1:0] a);
        return a[OFFSET+IDX-1:OFFSET];
    endfunction

    function automatic logic [TAGW-1:0] tag_of(input logic [AWIDTH-1:0] a);
        return a[AWIDTH-1:OFFSET+IDX];
    endfunction

    assign ra[0] = ra0;
    assign ra[1] = ra1;
    assign busy  = (state == BP_FLUSH);

    // A flush request in the same cycle pre-empts the write.
    assign we_eff = we && (state == BP_IDLE) && !flush;

    // Per-port tag compare across all ways of the indexed set.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rset[p]  = idx_of(ra[p]);
            rtag[p]  = tag_of(ra[p]);
            rway[p]  = '0;
            rdata[p] = '0;
            rhit[p]  = 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                if (valid_mem[rset[p]][w] && (tag_mem[w][rset[p]] == rtag[p])) begin
                    rhit[p]  = 1'b1;
                    rway[p]  = WW'(w);
                    rdata[p] = data_mem[w][rset[p]];
                end
            end
        end
    end

    // Write-side lookup: hit way, and lowest invalid way for allocation.
    always_comb begin
        wset      = idx_of(wa);
        wtag      = tag_of(wa);
        whit      = 1'b0;
        wway_hit  = '0;
        any_inv   = 1'b0;
        first_inv = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_mem[wset][w] && (tag_mem[w][wset] == wtag)) begin
                whit     = 1'b1;
                wway_hit = WW'(w);
            end
            if (!valid_mem[wset][w]) begin
                any_inv   = 1'b1;
                first_inv = WW'(w);
            end
        end
    end

    // Way receiving the write: existing hit, else first invalid, else PLRU victim.
    always_comb begin
        if (whit)         wway = wway_hit;
        else if (any_inv) wway = first_inv;
        else              wway = wvictim;
    end

    bp_plru_tree #(.WAYS(WAYS)) u_wtree (
        .bits      (plru_mem[wset]),
        .way       (wway),
        .valid     (1'b1),
        .bits_next (wplru_next),
        .victim    (wvictim)
    );

    for (genvar p = 0; p < 2; p++) begin : g_rtree
        bp_plru_tree #(.WAYS(WAYS)) u_rtree (
            .bits      (plru_mem[rset[p]]),
            .way       (rway[p]),
            .valid     (rhit[p]),
            .bits_next (rplru_next[p]),
            .victim    (rvictim_unused[p])
        );
    end

    // Read-hit PLRU updates yield to the write, and port 1 also yields to port 0.
    always_comb begin
        upd0 = !busy && rhit[0] && !(we_eff && (rset[0] == wset));
        upd1 = !busy && rhit[1] && !(we_eff && (rset[1] == wset))
                                && !(upd0 && (rset[1] == rset[0]));
    end

    // Read outputs, masked while the flush walk is in progress.
    always_comb begin
        hit0  = rhit[0] && !busy;
        hit1  = rhit[1] && !busy;
        dout0 = hit0 ? rdata[0] : '0;
        dout1 = hit1 ? rdata[1] : '0;
`ifdef BP_CACHE_FWD_EN
        if (we_eff && (rset[0] == wset) && (rtag[0] == wtag)) begin
            hit0  = 1'b1;
            dout0 = din;
        end
        if (we_eff && (rset[1] == wset) && (rtag[1] == wtag)) begin
            hit1  = 1'b1;
            dout1 = din;
        end
`endif
    end

    // Flush FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BP_IDLE;
        else       state <= state_next;
    end

    // Flush FSM next state: one set per cycle until the last set is cleared.
    always_comb begin
        state_next = state;
        case (state)
            BP_IDLE:  if (flush) state_next = BP_FLUSH;
            BP_FLUSH: if (cnt == IDX'(SETS - 1)) state_next = BP_IDLE;
            default:  state_next = BP_IDLE;
        endcase
    end

    // Set counter: held at 0 while idle, steps through the sets during a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          cnt <= '0;
        else if (state == BP_IDLE)          cnt <= '0;
        else if (cnt == IDX'(SETS - 1))     cnt <= '0;
        else                                cnt <= cnt + 1'b1;
    end

    // Valid and PLRU state: cleared by reset or the flush walk, else updated by accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                plru_mem[s]  <= '0;
            end
        end else if (state == BP_FLUSH) begin
            valid_mem[cnt] <= '0;
            plru_mem[cnt]  <= '0;
        end else begin
            if (we_eff) begin
                valid_mem[wset][wway] <= 1'b1;
                plru_mem[wset]        <= wplru_next;
            end
            if (upd0) plru_mem[rset[0]] <= rplru_next[0];
            if (upd1) plru_mem[rset[1]] <= rplru_next[1];
        end
    end

    // Tag and payload storage; not reset since valid bits gate every use.
    always_ff @(posedge clk) begin
        if (we_eff) begin
            tag_mem[wway][wset]  <= wtag;
            data_mem[wway][wset] <= din;
        end
    end

endmodule

// File: tb/tb_bp_cache_nway.sv
// Bench for bp_cache_nway (LINES=128, WAYS=4, OFFSET=0: 32 sets, index a[4:0]).
// Reference model keeps per-set way lists and a 1-based heap PLRU tree.
module tb_bp_cache_nway;

    localparam int SETS = 32;
    localparam int WAYS = 4;
    localparam logic [31:0] IDLE_A = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ra0, ra1, wa, din, dout0, dout1;
    logic        hit0, hit1, we, flush, busy;

    int total = 0;
    int bad   = 0;

    bit          m_valid [SETS][WAYS];
    logic [26:0] m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS];
    bit          m_tree  [SETS][WAYS];
    bit          m_busy;
    int          m_ptr;

    logic        e_hit0, e_hit1, e_busy, o_hit0, o_hit1, o_busy;
    logic [31:0] e_dout0, e_dout1, o_dout0, o_dout1;

    bp_cache_nway #(.AWIDTH(32), .DWIDTH(32), .LINES(128), .WAYS(4), .OFFSET(0)) dut (
        .clk(clk), .reset(reset),
        .ra0(ra0), .dout0(dout0), .hit0(hit0),
        .ra1(ra1), .dout1(dout1), .hit1(hit1),
        .wa(wa), .din(din), .we(we), .flush(flush), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int set_of(input logic [31:0] a);
        return int'(a[4:0]);
    endfunction

    task automatic m_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_tree[s][w]  = 0;
            end
        m_busy = 0;
        m_ptr  = 0;
    endtask

    task automatic m_lookup(input logic [31:0] a, output bit h, output logic [31:0] d, output int way);
        int s;
        s = set_of(a); h = 0; d = '0; way = 0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:5]) begin
                h = 1; d = m_data[s][w]; way = w;
            end
    endtask

    function automatic int m_victim(input int s);
        int node;
        node = 1;
        while (node < WAYS) node = 2 * node + int'(m_tree[s][node]);
        return node - WAYS;
    endfunction

    task automatic m_touch(input int s, input int way);
        int node;
        node = way + WAYS;
        while (node > 1) begin
            m_tree[s][node / 2] = (node % 2 == 0);
            node = node / 2;
        end
    endtask

    task automatic m_update(input logic s_we, input logic [31:0] s_wa, s_din, s_ra0, s_ra1,
                            input logic s_flush, input bit h0, input int w0, input bit h1, input int w1);
        int s0, s1, ws, way;
        bit u0, u1, wh;
        logic [31:0] dd;
        if (m_busy) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[m_ptr][w] = 0;
                m_tree[m_ptr][w]  = 0;
            end
            m_ptr++;
            if (m_ptr == SETS) begin m_busy = 0; m_ptr = 0; end
            return;
        end
        if (s_flush) begin m_busy = 1; m_ptr = 0; return; end
        s0 = set_of(s_ra0); s1 = set_of(s_ra1); ws = set_of(s_wa);
        u0 = h0 && !(s_we && s0 == ws);
        u1 = h1 && !(s_we && s1 == ws) && !(u0 && s1 == s0);
        if (s_we) begin
            m_lookup(s_wa, wh, dd, way);
            if (!wh) begin
                way = -1;
                for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[ws][w]) way = w;
                if (way < 0) way = m_victim(ws);
            end
            m_valid[ws][way] = 1;
            m_tag[ws][way]   = s_wa[31:5];
            m_data[ws][way]  = s_din;
            m_touch(ws, way);
        end
        if (u0) m_touch(s0, w0);
        if (u1) m_touch(s1, w1);
    endtask

    // One clock cycle: drive, sample DUT and model expectations, advance both.
    task automatic step(input logic s_we, input logic [31:0] s_wa, s_din, s_ra0, s_ra1, input logic s_flush);
        bit h0, h1;
        logic [31:0] d0, d1;
        int w0, w1;
        we = s_we; wa = s_wa; din = s_din; ra0 = s_ra0; ra1 = s_ra1; flush = s_flush;
        #1;
        m_lookup(s_ra0, h0, d0, w0);
        m_lookup(s_ra1, h1, d1, w1);
        e_hit0 = h0 && !m_busy; e_dout0 = e_hit0 ? d0 : '0;
        e_hit1 = h1 && !m_busy; e_dout1 = e_hit1 ? d1 : '0;
`ifdef BP_CACHE_FWD_EN
        if (s_we && !m_busy && !s_flush) begin
            if (s_ra0 == s_wa) begin e_hit0 = 1; e_dout0 = s_din; end
            if (s_ra1 == s_wa) begin e_hit1 = 1; e_dout1 = s_din; end
        end
`endif
        e_busy = m_busy;
        o_hit0 = hit0; o_dout0 = dout0; o_hit1 = hit1; o_dout1 = dout1; o_busy = busy;
        m_update(s_we, s_wa, s_din, s_ra0, s_ra1, s_flush, h0, w0, h1, w1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1; we = 0; flush = 0; wa = '0; din = '0; ra0 = IDLE_A; ra1 = IDLE_A;
        @(posedge clk);
        @(negedge clk) reset = 0;
        m_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 0, 0, 32'h100, 32'h0, 0);
        total += 5;
        if (o_hit0 !== 1'b0)   begin bad++; $display("FAIL reset_hit0 got=%0b want=0", o_hit0); end
        if (o_hit1 !== 1'b0)   begin bad++; $display("FAIL reset_hit1 got=%0b want=0", o_hit1); end
        if (o_dout0 !== 32'h0) begin bad++; $display("FAIL reset_dout0 got=%0h want=0", o_dout0); end
        if (o_dout1 !== 32'h0) begin bad++; $display("FAIL reset_dout1 got=%0h want=0", o_dout1); end
        if (o_busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%0b want=0", o_busy); end
    endtask

    task automatic test_write_read();
        step(1, 32'h100, 32'hAA, IDLE_A, IDLE_A, 0);
        step(0, 0, 0, 32'h100, 32'h120, 0);
        total += 3;
        if (o_hit0 !== 1'b1)    begin bad++; $display("FAIL wr_hit0 got=%0b want=1", o_hit0); end
        if (o_dout0 !== 32'hAA) begin bad++; $display("FAIL wr_dout0 got=%0h want=aa", o_dout0); end
        if (o_hit1 !== 1'b0)    begin bad++; $display("FAIL wr_hit1 got=%0b want=0", o_hit1); end
    endtask

    task automatic test_plru();
        logic [31:0] chk [5];
        chk = '{32'h40, 32'h00, 32'h20, 32'h60, 32'h80};
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 32'h20 * i, 32'h20 * i + 1, IDLE_A, IDLE_A, 0);
        step(0, 0, 0, 32'h00, IDLE_A, 0);
        step(1, 32'h80, 32'h81, IDLE_A, IDLE_A, 0);
        foreach (chk[i]) begin
            step(0, 0, 0, chk[i], IDLE_A, 0);
            total += 2;
            if (o_hit0 !== (chk[i] != 32'h40))
                begin bad++; $display("FAIL plru_hit a=%0h got=%0b want=%0b", chk[i], o_hit0, chk[i] != 32'h40); end
            if (o_dout0 !== ((chk[i] == 32'h40) ? 32'h0 : chk[i] + 1))
                begin bad++; $display("FAIL plru_dout a=%0h got=%0h want=%0h", chk[i], o_dout0, e_dout0); end
        end
    endtask

    task automatic test_flush();
        int n;
        logic [31:0] old [5];
        old = '{32'h00, 32'h20, 32'h60, 32'h80, 32'h200};
        step(0, 0, 0, IDLE_A, IDLE_A, 1);
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL flush_req_busy got=%0b want=0", o_busy); end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(i == 0, 32'h200, 32'h99, 32'h20, IDLE_A, 0);
            if (o_busy) n++;
            total += 2;
            if (o_busy !== e_busy) begin bad++; $display("FAIL flush_busy cyc=%0d got=%0b want=%0b", i, o_busy, e_busy); end
            if (o_hit0 !== e_hit0) begin bad++; $display("FAIL flush_hit0 cyc=%0d got=%0b want=%0b", i, o_hit0, e_hit0); end
        end
        total++;
        if (n !== 32) begin bad++; $display("FAIL flush_len got=%0d want=32", n); end
        foreach (old[i]) begin
            step(0, 0, 0, old[i], old[i], 0);
            total += 2;
            if (o_hit0 !== 1'b0) begin bad++; $display("FAIL flush_miss0 a=%0h got=%0b want=0", old[i], o_hit0); end
            if (o_hit1 !== 1'b0) begin bad++; $display("FAIL flush_miss1 a=%0h got=%0b want=0", old[i], o_hit1); end
        end
    endtask

    task automatic test_forward();
        logic fh;
        logic [31:0] fd;
`ifdef BP_CACHE_FWD_EN
        fh = 1'b1; fd = 32'h5;
`else
        fh = 1'b0; fd = 32'h0;
`endif
        step(1, 32'h44, 32'h5, 32'h44, IDLE_A, 0);
        total += 2;
        if (o_hit0 !== fh)  begin bad++; $display("FAIL fwd_hit0 got=%0b want=%0b", o_hit0, fh); end
        if (o_dout0 !== fd) begin bad++; $display("FAIL fwd_dout0 got=%0h want=%0h", o_dout0, fd); end
        step(0, 0, 0, 32'h44, IDLE_A, 0);
        total += 2;
        if (o_hit0 !== 1'b1)   begin bad++; $display("FAIL fwd_next_hit0 got=%0b want=1", o_hit0); end
        if (o_dout0 !== 32'h5) begin bad++; $display("FAIL fwd_next_dout0 got=%0h want=5", o_dout0); end
    endtask

    task automatic test_reset_mid_flush();
        step(1, 32'h10, 32'h11, IDLE_A, IDLE_A, 0);
        step(1, 32'h30, 32'h31, IDLE_A, IDLE_A, 0);
        step(0, 0, 0, IDLE_A, IDLE_A, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, IDLE_A, IDLE_A, 0);
        reset = 1;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL midflush_busy got=%0b want=0", busy); end
        m_reset();
        @(negedge clk) reset = 0;
        @(posedge clk); #1;
        step(0, 0, 0, 32'h10, 32'h30, 0);
        total += 3;
        if (o_hit0 !== 1'b0) begin bad++; $display("FAIL midflush_miss0 got=%0b want=0", o_hit0); end
        if (o_hit1 !== 1'b0) begin bad++; $display("FAIL midflush_miss1 got=%0b want=0", o_hit1); end
        if (o_busy !== 1'b0) begin bad++; $display("FAIL midflush_idle got=%0b want=0", o_busy); end
        step(1, 32'h10, 32'h77, IDLE_A, IDLE_A, 0);
        step(0, 0, 0, 32'h10, IDLE_A, 0);
        total += 2;
        if (o_hit0 !== 1'b1)    begin bad++; $display("FAIL midflush_hit got=%0b want=1", o_hit0); end
        if (o_dout0 !== 32'h77) begin bad++; $display("FAIL midflush_dout got=%0h want=77", o_dout0); end
    endtask

    // Narrow address pool (4 sets x 6 tags) so sets overflow and PLRU matters.
    function automatic logic [31:0] rnd_addr();
        return ({27'(0), 5'(0)} | (32'($urandom_range(0, 5)) << 5) | 32'($urandom_range(0, 3)));
    endfunction

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, rnd_addr(), $urandom(), rnd_addr(), rnd_addr(),
                 $urandom_range(0, 149) == 0);
            total += 5;
            if (o_hit0 !== e_hit0)   begin bad++; $display("FAIL rnd_hit0 i=%0d got=%0b want=%0b", i, o_hit0, e_hit0); end
            if (o_dout0 !== e_dout0) begin bad++; $display("FAIL rnd_dout0 i=%0d got=%0h want=%0h", i, o_dout0, e_dout0); end
            if (o_hit1 !== e_hit1)   begin bad++; $display("FAIL rnd_hit1 i=%0d got=%0b want=%0b", i, o_hit1, e_hit1); end
            if (o_dout1 !== e_dout1) begin bad++; $display("FAIL rnd_dout1 i=%0d got=%0h want=%0h", i, o_dout1, e_dout1); end
            if (o_busy !== e_busy)   begin bad++; $display("FAIL rnd_busy i=%0d got=%0b want=%0b", i, o_busy, e_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_plru();
        test_flush();
        test_forward();
        test_reset_mid_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
